// File: rtl/thread_issue_sched_if.sv
// Issue-scheduler port bundle: control inputs from the pipeline, issue decision back.
// master drives the requests; slave is the scheduler.
interface thread_issue_sched_if #(
  parameter int THREAD_BITS = 2,
  parameter int NUM_THREADS = 4,
  parameter int WAIT_BITS   = 4
);
  logic                   en;
  logic [NUM_THREADS-1:0] thread_mask;
  logic                   block_req;
  logic [THREAD_BITS-1:0] block_thread;
  logic [WAIT_BITS-1:0]   block_cycles;
  logic                   wake_req;
  logic [THREAD_BITS-1:0] wake_thread;
  logic                   issue_valid;
  logic [THREAD_BITS-1:0] issue_thread;
  logic [NUM_THREADS-1:0] thread_ready;
  logic                   all_idle;

  modport master (
    output en, thread_mask, block_req, block_thread, block_cycles, wake_req, wake_thread,
    input  issue_valid, issue_thread, thread_ready, all_idle
  );

  modport slave (
    input  en, thread_mask, block_req, block_thread, block_cycles, wake_req, wake_thread,
    output issue_valid, issue_thread, thread_ready, all_idle
  );
endinterface

// File: rtl/thread_issue_sched.sv
// Fine-grained multithreading issue scheduler: per-thread run/wait tracking
// with timed and event waits, round-robin selection with one-cycle latency.
module thread_issue_sched #(
  parameter int THREAD_BITS = 2,
  parameter int NUM_THREADS = 4,
  parameter int WAIT_BITS   = 4
) (
  input logic                  clk,
  input logic                  reset,
  thread_issue_sched_if.slave  sched_io
);

  // OFF is never stored; it is derived from thread_mask at readiness time.
  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_WAIT_T = 2'd1,
    ST_WAIT_E = 2'd2,
    ST_OFF    = 2'd3
  } state_e;

  state_e                 state_q [NUM_THREADS];
  state_e                 state_d [NUM_THREADS];
  logic [WAIT_BITS-1:0]   cnt_q   [NUM_THREADS];
  logic [WAIT_BITS-1:0]   cnt_d   [NUM_THREADS];
  logic [THREAD_BITS-1:0] last_q, last_d;
  logic                   issue_valid_q, issue_valid_d;
  logic [THREAD_BITS-1:0] issue_thread_q, issue_thread_d;
  logic [NUM_THREADS-1:0] ready_q, ready_d;
  logic                   all_idle_q, all_idle_d;
  logic                   found_s;
  logic [THREAD_BITS-1:0] sel_s;
  logic [THREAD_BITS-1:0] idx_s;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_THREADS; i++) begin
        state_q[i] <= ST_RUN;
        cnt_q[i]   <= {WAIT_BITS{1'b0}};
      end
      last_q         <= THREAD_BITS'(NUM_THREADS - 1);
      issue_valid_q  <= 1'b0;
      issue_thread_q <= {THREAD_BITS{1'b0}};
      ready_q        <= {NUM_THREADS{1'b0}};
      all_idle_q     <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_THREADS; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
      last_q         <= last_d;
      issue_valid_q  <= issue_valid_d;
      issue_thread_q <= issue_thread_d;
      ready_q        <= ready_d;
      all_idle_q     <= all_idle_d;
    end
  end

  // Next-state: countdown and wake first, then block overrides both
  always_comb begin
    for (int i = 0; i < NUM_THREADS; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      if (sched_io.en) begin
        case (state_q[i])
          ST_WAIT_T: begin
            if (cnt_q[i] <= WAIT_BITS'(1)) begin
              state_d[i] = ST_RUN;
              cnt_d[i]   = {WAIT_BITS{1'b0}};
            end else begin
              cnt_d[i]   = cnt_q[i] - WAIT_BITS'(1);
            end
          end
          ST_WAIT_E: begin
            if (sched_io.wake_req && (sched_io.wake_thread == THREAD_BITS'(i))) begin
              state_d[i] = ST_RUN;
            end else begin
              state_d[i] = ST_WAIT_E;
            end
          end
          default: state_d[i] = state_q[i];
        endcase
        if (sched_io.block_req && (sched_io.block_thread == THREAD_BITS'(i))) begin
          if (sched_io.block_cycles != {WAIT_BITS{1'b0}}) begin
            state_d[i] = ST_WAIT_T;
            cnt_d[i]   = sched_io.block_cycles;
          end else begin
            state_d[i] = ST_WAIT_E;
            cnt_d[i]   = {WAIT_BITS{1'b0}};
          end
        end else begin
          cnt_d[i] = cnt_d[i];
        end
      end else begin
        state_d[i] = state_q[i];
      end
    end
  end

  // Output: readiness from next-state, round-robin pick from current readiness
  always_comb begin
    found_s = 1'b0;
    sel_s   = last_q;
    idx_s   = last_q;
    for (int k = 1; k <= NUM_THREADS; k++) begin
      idx_s = last_q + THREAD_BITS'(k);
      if (!found_s && ready_q[idx_s]) begin
        found_s = 1'b1;
        sel_s   = idx_s;
      end else begin
        found_s = found_s;
      end
    end
    ready_d        = ready_q;
    issue_valid_d  = issue_valid_q;
    issue_thread_d = issue_thread_q;
    last_d         = last_q;
    all_idle_d     = all_idle_q;
    if (sched_io.en) begin
      for (int i = 0; i < NUM_THREADS; i++) begin
        ready_d[i] = sched_io.thread_mask[i] && (state_d[i] == ST_RUN);
      end
      issue_valid_d  = found_s;
      issue_thread_d = found_s ? sel_s : issue_thread_q;
      last_d         = found_s ? sel_s : last_q;
      all_idle_d     = !found_s;
    end else begin
      ready_d = ready_q;
    end
  end

  assign sched_io.issue_valid  = issue_valid_q;
  assign sched_io.issue_thread = issue_thread_q;
  assign sched_io.thread_ready = ready_q;
  assign sched_io.all_idle     = all_idle_q;

endmodule

// File: tb/tb_thread_issue_sched.sv
// Directed bench for thread_issue_sched: a per-cycle vector table plus
// hand-written sequences for enable freeze and mid-wait reset.
module tb_thread_issue_sched;

  typedef struct {
    logic [3:0] mask;
    logic       blk;
    logic [1:0] bt;
    logic [3:0] bc;
    logic       wk;
    logic [1:0] wt;
    logic       ev;
    logic [1:0] et;
    logic [3:0] er;
    logic       ei;
  } vec_t;

  logic clk;
  logic reset;
  int   total;
  int   bad;
  vec_t tbl[$];

  thread_issue_sched_if #(.THREAD_BITS(2), .NUM_THREADS(4), .WAIT_BITS(4)) sif ();

  thread_issue_sched #(.THREAD_BITS(2), .NUM_THREADS(4), .WAIT_BITS(4)) dut (
    .clk      (clk),
    .reset    (reset),
    .sched_io (sif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(logic [3:0] mask, logic blk, logic [1:0] bt, logic [3:0] bc,
                              logic wk, logic [1:0] wt, logic ev, logic [1:0] et,
                              logic [3:0] er, logic ei);
    vec_t v;
    v.mask = mask; v.blk = blk; v.bt = bt; v.bc = bc; v.wk = wk; v.wt = wt;
    v.ev = ev; v.et = et; v.er = er; v.ei = ei;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [7:0] got, input logic [7:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  task automatic chk_all(input string nm, input logic ev, input logic [1:0] et,
                         input logic [3:0] er, input logic ei);
    chk({nm, ".valid"}, {7'd0, sif.issue_valid}, {7'd0, ev});
    chk({nm, ".thread"}, {6'd0, sif.issue_thread}, {6'd0, et});
    chk({nm, ".ready"}, {4'd0, sif.thread_ready}, {4'd0, er});
    chk({nm, ".idle"}, {7'd0, sif.all_idle}, {7'd0, ei});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic en, input logic [3:0] mask, input logic blk,
                        input logic [1:0] bt, input logic [3:0] bc,
                        input logic wk, input logic [1:0] wt);
    sif.en = en; sif.thread_mask = mask; sif.block_req = blk; sif.block_thread = bt;
    sif.block_cycles = bc; sif.wake_req = wk; sif.wake_thread = wt;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b1;
    set_in(1'b1, 4'hF, 1'b0, 2'd0, 4'd0, 1'b0, 2'd0);

    // round robin, mask 0101, mask off, timed wait, event wait, block+wake
    tbl.push_back(mk(4'hF, 1'b0, 2'd0, 4'd0, 1'b0, 2'd0, 1'b0, 2'd0, 4'hF, 1'b1));
    tbl.push_back(mk(4'hF, 1'b0, 2'd0, 4'd0, 1'b0, 2'd0, 1'b1, 2'd0, 4'hF, 1'b0));
    tbl.push_back(mk(4'hF, 1'b0, 2'd0, 4'd0, 1'b0, 2'd0, 1'b1, 2'd1, 4'hF, 1'b0));
    tbl.push_back(mk(4'hF, 1'b0, 2'd0, 4'd0, 1'b0, 2'd0, 1'b1, 2'd2, 4'hF, 1'b0));
    tbl.push_back(mk(4'hF, 1'b0, 2'd0, 4'd0, 1'b0, 2'd0, 1'b1, 2'd3, 4'hF, 1'b0));
    tbl.push_back(mk(4'hF, 1'b0, 2'd0, 4'd0, 1'b0, 2'd0, 1'b1, 2'd0, 4'hF, 1'b0));
    tbl.push_back(mk(4'h5, 1'b0, 2'd0, 4'd0, 1'b0, 2'd0, 1'b1, 2'd1, 4'h5, 1'b0));
    tbl.push_back(mk(4'h5, 1'b0, 2'd0, 4'd0, 1'b0, 2'd0, 1'b1, 2'd2, 4'h5, 1'b0));
    tbl.push_back(mk(4'h5, 1'b0, 2'd0, 4'd0, 1'b0, 2'd0, 1'b1, 2'd0, 4'h5, 1'b0));
    tbl.push_back(mk(4'h0, 1'b0, 2'd0, 4'd0, 1'b0, 2'd0, 1'b1, 2'd2, 4'h0, 1'b0));
    tbl.push_back(mk(4'h0, 1'b0, 2'd0, 4'd0, 1'b0, 2'd0, 1'b0, 2'd2, 4'h0, 1'b1));
    tbl.push_back(mk(4'hF, 1'b0, 2'd0, 4'd0, 1'b0, 2'd0, 1'b0, 2'd2, 4'hF, 1'b1));
    tbl.push_back(mk(4'hF, 1'b0, 2'd0, 4'd0, 1'b0, 2'd0, 1'b1, 2'd3, 4'hF, 1'b0));
    tbl.push_back(mk(4'hF, 1'b1, 2'd1, 4'd3, 1'b0, 2'd0, 1'b1, 2'd0, 4'hD, 1'b0));
    tbl.push_back(mk(4'hF, 1'b0, 2'd0, 4'd0, 1'b0, 2'd0, 1'b1, 2'd2, 4'hD, 1'b0));
    tbl.push_back(mk(4'hF, 1'b0, 2'd0, 4'd0, 1'b0, 2'd0, 1'b1, 2'd3, 4'hD, 1'b0));
    tbl.push_back(mk(4'hF, 1'b0, 2'd0, 4'd0, 1'b0, 2'd0, 1'b1, 2'd0, 4'hF, 1'b0));
    tbl.push_back(mk(4'hF, 1'b0, 2'd0, 4'd0, 1'b0, 2'd0, 1'b1, 2'd1, 4'hF, 1'b0));
    tbl.push_back(mk(4'hF, 1'b1, 2'd2, 4'd0, 1'b1, 2'd3, 1'b1, 2'd2, 4'hB, 1'b0));
    tbl.push_back(mk(4'hF, 1'b0, 2'd0, 4'd0, 1'b0, 2'd0, 1'b1, 2'd3, 4'hB, 1'b0));
    tbl.push_back(mk(4'hF, 1'b0, 2'd0, 4'd0, 1'b0, 2'd0, 1'b1, 2'd0, 4'hB, 1'b0));
    tbl.push_back(mk(4'hF, 1'b0, 2'd0, 4'd0, 1'b0, 2'd0, 1'b1, 2'd1, 4'hB, 1'b0));
    tbl.push_back(mk(4'hF, 1'b0, 2'd0, 4'd0, 1'b0, 2'd0, 1'b1, 2'd3, 4'hB, 1'b0));
    tbl.push_back(mk(4'hF, 1'b0, 2'd0, 4'd0, 1'b1, 2'd2, 1'b1, 2'd0, 4'hF, 1'b0));
    tbl.push_back(mk(4'hF, 1'b0, 2'd0, 4'd0, 1'b0, 2'd0, 1'b1, 2'd1, 4'hF, 1'b0));
    tbl.push_back(mk(4'hF, 1'b0, 2'd0, 4'd0, 1'b0, 2'd0, 1'b1, 2'd2, 4'hF, 1'b0));
    tbl.push_back(mk(4'hF, 1'b1, 2'd0, 4'd0, 1'b0, 2'd0, 1'b1, 2'd3, 4'hE, 1'b0));
    tbl.push_back(mk(4'hF, 1'b1, 2'd0, 4'd0, 1'b1, 2'd0, 1'b1, 2'd1, 4'hE, 1'b0));
    tbl.push_back(mk(4'hF, 1'b0, 2'd0, 4'd0, 1'b0, 2'd0, 1'b1, 2'd2, 4'hE, 1'b0));
    tbl.push_back(mk(4'hF, 1'b0, 2'd0, 4'd0, 1'b1, 2'd0, 1'b1, 2'd3, 4'hF, 1'b0));
    tbl.push_back(mk(4'hF, 1'b0, 2'd0, 4'd0, 1'b0, 2'd0, 1'b1, 2'd0, 4'hF, 1'b0));

    tick();
    tick();
    chk_all("reset", 1'b0, 2'd0, 4'h0, 1'b0);
    reset = 1'b0;

    foreach (tbl[r]) begin
      set_in(1'b1, tbl[r].mask, tbl[r].blk, tbl[r].bt, tbl[r].bc, tbl[r].wk, tbl[r].wt);
      tick();
      chk_all($sformatf("row%0d", r), tbl[r].ev, tbl[r].et, tbl[r].er, tbl[r].ei);
    end

    // timed wait of 4 on thread 1, frozen with counter at 2
    set_in(1'b1, 4'hF, 1'b1, 2'd1, 4'd4, 1'b0, 2'd0);
    tick(); chk_all("tw_a", 1'b1, 2'd1, 4'hD, 1'b0);
    set_in(1'b1, 4'hF, 1'b0, 2'd0, 4'd0, 1'b0, 2'd0);
    tick(); chk_all("tw_b", 1'b1, 2'd2, 4'hD, 1'b0);
    tick(); chk_all("tw_c", 1'b1, 2'd3, 4'hD, 1'b0);
    set_in(1'b0, 4'hF, 1'b1, 2'd1, 4'd9, 1'b1, 2'd1);
    for (int c = 0; c < 5; c++) begin
      tick();
      chk_all($sformatf("frz%0d", c), 1'b1, 2'd3, 4'hD, 1'b0);
    end
    set_in(1'b1, 4'hF, 1'b0, 2'd0, 4'd0, 1'b0, 2'd0);
    tick(); chk_all("rel_1", 1'b1, 2'd0, 4'hD, 1'b0);
    tick(); chk_all("rel_2", 1'b1, 2'd2, 4'hF, 1'b0);
    tick(); chk_all("rel_3", 1'b1, 2'd3, 4'hF, 1'b0);

    // event-block thread 2, then reset in the middle of the wait
    set_in(1'b1, 4'hF, 1'b1, 2'd2, 4'd0, 1'b0, 2'd0);
    tick(); chk_all("rst_pre", 1'b1, 2'd0, 4'hB, 1'b0);
    set_in(1'b1, 4'hF, 1'b0, 2'd0, 4'd0, 1'b0, 2'd0);
    reset = 1'b1;
    tick(); chk_all("rst_in", 1'b0, 2'd0, 4'h0, 1'b0);
    reset = 1'b0;
    tick(); chk_all("rst_p1", 1'b0, 2'd0, 4'hF, 1'b1);
    tick(); chk_all("rst_p2", 1'b1, 2'd0, 4'hF, 1'b0);
    tick(); chk_all("rst_p3", 1'b1, 2'd1, 4'hF, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
